disp_scan_arbiter: RTL and testbench



---
 rtl/disp_pkg.sv | 39 +++
 rtl/disp_scan_arbiter_if.sv | 22 ++
 rtl/disp_prescaler.sv | 43 ++++
 rtl/disp_scan_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_disp_scan_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment display blocks: digit geometry,
// anode drive patterns, the arbiter FSM state type and the round-robin helper.
package disp_pkg;

    localparam int DIGIT_W  = 4;
    localparam int N_DIGITS = 4;
    localparam int MAX_SRC  = 8;

    // Active-low anode drive; slot 0 is the leftmost (most significant) digit.
    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam logic [3:0] ANODE_SLOT [0:3] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } disp_state_e;

    // Round-robin pick: scan ptr+1, ptr+2, ... modulo n, the pointer itself last.
    // Returns {found, index}.
    function automatic logic [3:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int unsigned n);
        logic [3:0]  res;
        int unsigned idx;
        int unsigned ptr_i;
        res   = 4'b0000;
        ptr_i = 32'(ptr);
        for (int unsigned k = 1; k <= 8; k++) begin
            idx = (ptr_i + k) % n;
            if ((k <= n) && !res[3] && req[idx[2:0]]) begin
                res = {1'b1, idx[2:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/disp_scan_arbiter_if.sv
// Requester/display bus of the scan arbiter. The arbiter uses the slave view;
// the system side (requesters and the segment decoder) uses the master view.
interface disp_scan_arbiter_if #(parameter int N_SRC = 4);

    logic [N_SRC-1:0]    req;
    logic [16*N_SRC-1:0] data;
    logic [N_SRC-1:0]    grant;
    logic [3:0]          digit;
    logic [3:0]          anode;
    logic                frame_end;

    modport master (
        output req, data,
        input  grant, digit, anode, frame_end
    );

    modport slave (
        input  req, data,
        output grant, digit, anode, frame_end
    );

endinterface

// File: rtl/disp_prescaler.sv
// Digit-scan timebase: divides clk by PRESCALE into slot ticks and steps a
// 2-bit slot index 0..3. Reusable by any 4-digit multiplexed display.
module disp_prescaler #(
    parameter int PRESCALE = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       tick,
    output logic [1:0] slot
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt_r;
    logic [1:0]    slot_r;

    assign tick = (pcnt_r == PCNT_LAST);
    assign slot = slot_r;

    // Prescale counter 0..PRESCALE-1, wrapping on the tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_r <= {PW{1'b0}};
        end else if (tick) begin
            pcnt_r <= {PW{1'b0}};
        end else begin
            pcnt_r <= pcnt_r + PW'(1);
        end
    end

    // Slot index advances once per tick and wraps 3 -> 0 naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_r <= 2'd0;
        end else if (tick) begin
            slot_r <= slot_r + 2'd1;
        end else begin
            slot_r <= slot_r;
        end
    end

endmodule

// File: rtl/disp_scan_arbiter.sv
// Shares one 4-digit seven-segment display among N_SRC requesters.
// Ownership is round-robin and only changes on frame boundaries; the shown
// value is a per-frame snapshot so a digit group never tears.
// Build option: define DISP_BLANK_LEADING_EN to blank leading zero digits
// (the rightmost digit always stays lit).
module disp_scan_arbiter
    import disp_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int PRESCALE     = 50000,
    parameter int DWELL_FRAMES = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    disp_scan_arbiter_if.slave   bus
);

    localparam int DCW = $clog2(DWELL_FRAMES + 1);
    localparam logic [DCW-1:0] DWELL_MAX = DCW'(DWELL_FRAMES);
    localparam logic [2:0]     PTR_INIT  = 3'(N_SRC - 1);

    // Timebase
    logic       tick_s;
    logic [1:0] slot_s;
    logic       frame_bound_s;

    disp_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick_s),
        .slot    (slot_s)
    );

    assign frame_bound_s = tick_s && (slot_s == 2'd3);

    // Arbitration state
    disp_state_e       state_r;
    disp_state_e       state_next_s;
    logic [2:0]        ptr_r;
    logic [N_SRC-1:0]  grant_r;
    logic [15:0]       snap_r;
    logic [DCW-1:0]    dwell_r;

    logic [7:0]        req8_s;
    logic [3:0]        pick_s;
    logic              pick_found_s;
    logic [2:0]        pick_idx_s;
    logic              owner_req_s;
    logic              other_req_s;
    logic [DCW-1:0]    dwell_inc_s;
    logic [15:0]       pick_data_s;
    logic [15:0]       own_data_s;
    logic [N_SRC-1:0]  grant_pick_s;
    logic              do_switch_s;
    logic              do_keep_s;
    logic              do_idle_s;

    logic [3:0]        anode_s;
    logic [3:0]        digit_s;

    // Widen the request vector to the helper's fixed 8-bit view.
    always_comb begin
        req8_s               = 8'b0000_0000;
        req8_s[N_SRC-1:0]    = bus.req;
    end

    assign pick_s       = rr_pick(req8_s, ptr_r, N_SRC);
    assign pick_found_s = pick_s[3];
    assign pick_idx_s   = pick_s[2:0];

    // In SHOW the pointer always names the current owner.
    assign owner_req_s = req8_s[ptr_r];
    assign other_req_s = |(req8_s & ~(8'b0000_0001 << ptr_r));
    assign dwell_inc_s = (dwell_r == DWELL_MAX) ? dwell_r : (dwell_r + DCW'(1));

    // Select the data word of the picked source and of the current owner.
    always_comb begin
        pick_data_s  = 16'h0000;
        own_data_s   = 16'h0000;
        grant_pick_s = {N_SRC{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            if (3'(i) == pick_idx_s) begin
                pick_data_s     = bus.data[16*i +: 16];
                grant_pick_s[i] = 1'b1;
            end else begin
                grant_pick_s[i] = 1'b0;
            end
            if (3'(i) == ptr_r) begin
                own_data_s = bus.data[16*i +: 16];
            end else begin
                own_data_s = own_data_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and boundary decisions; nothing moves off a frame boundary.
    always_comb begin
        state_next_s = state_r;
        do_switch_s  = 1'b0;
        do_keep_s    = 1'b0;
        do_idle_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (frame_bound_s && pick_found_s) begin
                    state_next_s = SHOW;
                    do_switch_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHOW: begin
                if (!frame_bound_s) begin
                    state_next_s = SHOW;
                end else if (!owner_req_s) begin
                    if (other_req_s) begin
                        do_switch_s = 1'b1;
                    end else begin
                        state_next_s = IDLE;
                        do_idle_s    = 1'b1;
                    end
                end else if ((dwell_inc_s >= DWELL_MAX) && other_req_s) begin
                    do_switch_s = 1'b1;
                end else begin
                    do_keep_s = 1'b1;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Ownership datapath: pointer, grant, snapshot and dwell counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r   <= PTR_INIT;
            grant_r <= {N_SRC{1'b0}};
            snap_r  <= 16'h0000;
            dwell_r <= {DCW{1'b0}};
        end else if (do_switch_s) begin
            ptr_r   <= pick_idx_s;
            grant_r <= grant_pick_s;
            snap_r  <= pick_data_s;
            dwell_r <= {DCW{1'b0}};
        end else if (do_keep_s) begin
            snap_r  <= own_data_s;
            dwell_r <= dwell_inc_s;
        end else if (do_idle_s) begin
            grant_r <= {N_SRC{1'b0}};
            dwell_r <= {DCW{1'b0}};
        end else begin
            ptr_r   <= ptr_r;
        end
    end

    // FSM outputs: drive the current slot from the snapshot while showing.
    always_comb begin
        anode_s = ANODE_OFF;
        digit_s = 4'h0;
        if (state_r == SHOW) begin
            case (slot_s)
                2'd0:    digit_s = snap_r[15:12];
                2'd1:    digit_s = snap_r[11:8];
                2'd2:    digit_s = snap_r[7:4];
                2'd3:    digit_s = snap_r[3:0];
                default: digit_s = 4'h0;
            endcase
            anode_s = ANODE_SLOT[slot_s];
`ifdef DISP_BLANK_LEADING_EN
            // A slot is dark when it and every more significant nibble are zero.
            case (slot_s)
                2'd0: begin
                    if (snap_r[15:12] == 4'h0) begin
                        anode_s = ANODE_OFF;
                        digit_s = 4'h0;
                    end else begin
                        anode_s = anode_s;
                    end
                end
                2'd1: begin
                    if (snap_r[15:8] == 8'h00) begin
                        anode_s = ANODE_OFF;
                        digit_s = 4'h0;
                    end else begin
                        anode_s = anode_s;
                    end
                end
                2'd2: begin
                    if (snap_r[15:4] == 12'h000) begin
                        anode_s = ANODE_OFF;
                        digit_s = 4'h0;
                    end else begin
                        anode_s = anode_s;
                    end
                end
                default: begin
                    anode_s = anode_s;
                end
            endcase
`endif
        end else begin
            anode_s = ANODE_OFF;
            digit_s = 4'h0;
        end
    end

    assign bus.grant     = grant_r;
    assign bus.anode     = anode_s;
    assign bus.digit     = digit_s;
    assign bus.frame_end = frame_bound_s;

endmodule

// File: tb/tb_disp_scan_arbiter.sv
// Self-checking bench for disp_scan_arbiter with PRESCALE=4, DWELL_FRAMES=2.
// A frame-level reference model tracks owner, dwell frames and snapshot, and
// derives the expected scan outputs from elapsed cycles since reset.
module tb_disp_scan_arbiter;

    localparam int N  = 4;
    localparam int PS = 4;
    localparam int DW = 2;
    localparam int FRAME = 4 * PS;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    logic [15:0]  dval [N];
    logic [N-1:0] rq;

    disp_scan_arbiter_if #(.N_SRC(N)) bus ();

    assign bus.req = rq;
    for (genvar g = 0; g < N; g++) begin : g_data
        assign bus.data[16*g +: 16] = dval[g];
    end

    disp_scan_arbiter #(
        .N_SRC        (N),
        .PRESCALE     (PS),
        .DWELL_FRAMES (DW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          t;
    int          owner;
    int          ptr;
    int          held;
    logic [15:0] snap;
    bit          in_reset;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, t);
        end
    endtask

    function automatic int rr_model();
        for (int k = 1; k <= N; k++) begin
            if (rq[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit others_req();
        for (int j = 0; j < N; j++) begin
            if (j != owner && rq[j]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        in_reset = 1'b1;
        t        = 0;
        owner    = -1;
        ptr      = N - 1;
        held     = 0;
        snap     = 16'h0000;
    endtask

    // Apply one rising edge worth of model evolution using the current inputs.
    task automatic model_edge();
        int nxt;
        if (in_reset) return;
        if (t % FRAME == FRAME - 1) begin
            if (owner < 0) begin
                nxt = rr_model();
                if (nxt >= 0) begin
                    owner = nxt; ptr = nxt; held = 0; snap = dval[nxt];
                end
            end else begin
                held = (held + 1 > DW) ? DW : held + 1;
                if (!rq[owner] || (held >= DW && others_req())) begin
                    nxt = rr_model();
                    if (nxt >= 0 && nxt != owner) begin
                        owner = nxt; ptr = nxt; held = 0; snap = dval[nxt];
                    end else if (!rq[owner]) begin
                        owner = -1;
                    end else begin
                        snap = dval[owner];
                    end
                end else begin
                    snap = dval[owner];
                end
            end
        end
        t++;
    endtask

    task automatic check_outputs();
        int          slot;
        logic [15:0] sh;
        logic [3:0]  exp_anode;
        logic [3:0]  exp_digit;
        logic [3:0]  exp_grant;
        bit          lit;
        if (in_reset) begin
            chk("rst_grant", 16'(bus.grant), 16'h0);
            chk("rst_anode", 16'(bus.anode), 16'hF);
            chk("rst_digit", 16'(bus.digit), 16'h0);
            chk("rst_frame_end", 16'(bus.frame_end), 16'h0);
            return;
        end
        slot = (t / PS) % 4;
        exp_grant = (owner < 0) ? 4'b0000 : 4'(1 << owner);
        sh = snap >> (12 - 4 * slot);
`ifdef DISP_BLANK_LEADING_EN
        lit = (slot == 3) || (sh != 16'h0000);
`else
        lit = 1'b1;
`endif
        if (owner >= 0 && lit) begin
            exp_anode = ~(4'b1000 >> slot);
            exp_digit = sh[3:0];
        end else begin
            exp_anode = 4'b1111;
            exp_digit = 4'h0;
        end
        chk("grant", 16'(bus.grant), 16'(exp_grant));
        chk("anode", 16'(bus.anode), 16'(exp_anode));
        chk("digit", 16'(bus.digit), 16'(exp_digit));
        chk("frame_end", 16'(bus.frame_end), 16'(t % FRAME == FRAME - 1));
    endtask

    // One clock: check at the falling edge, advance model, wait next falling edge.
    task automatic cycle();
        check_outputs();
        model_edge();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int guard;
        rq = '0;
        for (int i = 0; i < N; i++) dval[i] = 16'h0000;
        model_reset();

        // Reset held low
        @(negedge clk);
        run(3);
        reset_n  = 1'b1;
        in_reset = 1'b0;

        // Idle scanning, frame_end every 16 cycles
        run(40);

        // Single requester showing 1234
        dval[0] = 16'h1234;
        dval[2] = 16'h5678;
        rq      = 4'b0001;
        run(45);

        // Second requester: ownership alternates after dwell
        rq = 4'b0101;
        run(150);

        // Owner data changes mid-frame (slot 1)
        rq = 4'b0001;
        guard = 0;
        while (!(owner == 0 && (t / PS) % 4 == 1) && guard < 200) begin
            cycle();
            guard++;
        end
        chk("wait_slot1", 16'(guard < 200), 16'h1);
        dval[0] = 16'hABCD;
        run(40);

        // Owner drops mid-frame with nobody else: finish frame then idle
        run(5);
        rq = 4'b0000;
        run(40);

        // Asynchronous reset in the middle of slot 2 while showing
        dval[0] = 16'h0007;
        rq      = 4'b0001;
        guard = 0;
        while (!(owner >= 0 && (t / PS) % 4 == 2) && guard < 200) begin
            cycle();
            guard++;
        end
        chk("wait_slot2", 16'(guard < 200), 16'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_grant", 16'(bus.grant), 16'h0);
        chk("async_anode", 16'(bus.anode), 16'hF);
        model_reset();
        @(negedge clk);
        run(2);
        reset_n  = 1'b1;
        in_reset = 1'b0;
        run(50);

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 19) == 0) rq = 4'($urandom);
            if ($urandom_range(0, 9) == 0)
                dval[$urandom_range(0, N - 1)] = 16'($urandom) >> (4 * $urandom_range(0, 4));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
